// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver: four-digit multiplexed 7-segment driver with tear-free
// frame update, blanking between digits and leading-zero suppression.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 12500,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int             c_CW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(REFRESH_DIV - 1);
    localparam logic [c_CW-1:0] c_BLANK = c_CW'(BLANK_CYCLES);

    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_digit;
    logic [15:0]     r_hold;
    logic            r_pending;
    logic [15:0]     r_disp;

    logic            w_slot_end;
    logic            w_frame_end;
    logic            w_blank;
    logic            w_suppress;
    logic [3:0]      w_nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_slot_end  = (r_cnt == c_LAST);
    assign w_frame_end = w_slot_end && (r_digit == 2'd3);
    assign w_blank     = (r_cnt < c_BLANK);
    assign w_nib       = r_disp[{r_digit, 2'b00} +: 4];

    // A digit is dark when it and every more-significant nibble are zero.
    always_comb begin
        w_suppress = 1'b0;
        case (r_digit)
            2'd1:    w_suppress = lz_en && (r_disp[15:4]  == 12'd0);
            2'd2:    w_suppress = lz_en && (r_disp[15:8]  == 8'd0);
            2'd3:    w_suppress = lz_en && (r_disp[15:12] == 4'd0);
            default: w_suppress = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_cnt      <= '0;
            r_digit    <= 2'd0;
            r_hold     <= 16'd0;
            r_pending  <= 1'b0;
            r_disp     <= 16'd0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                r_digit <= r_digit + 2'd1;
            end

            // Display takes the pre-load holding contents, so a load on the
            // boundary cycle stays pending for the following frame.
            if (w_frame_end && r_pending) begin
                r_disp    <= r_hold;
                r_pending <= 1'b0;
            end
            if (load) begin
                r_hold    <= value;
                r_pending <= 1'b1;
            end

            frame_done <= w_frame_end;
            if (w_blank || w_suppress) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << r_digit);
                seg <= hex_to_seg(w_nib);
                dp  <= ~dp_in[r_digit];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver: randomized and directed stimulus against a cycle-count
// based reference model of the scan driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .Reset      (rst),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: elapsed cycles since reset determine digit and slot position.
    int          m_t;
    logic [15:0] m_hold;
    logic [15:0] m_disp;
    bit          m_pend;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %h expected %h", tag, m_t, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        int         dig;
        int         c;
        logic [3:0] nib;
        bit         sup;
        bit         bound;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_t = 0; m_hold = 16'd0; m_disp = 16'd0; m_pend = 1'b0;
        end else begin
            dig   = (m_t / RD) % 4;
            c     = m_t % RD;
            nib   = m_disp[4*dig +: 4];
            sup   = lz_en && (dig != 0) && ((m_disp >> (4 * dig)) == 16'd0);
            bound = (m_t % FRAME) == FRAME - 1;
            e_fd  = bound;
            if (c < BC || sup) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << dig);
                e_seg = seg_tab[nib];
                e_dp  = ~dp_in[dig];
            end
            if (bound && m_pend) begin
                m_disp = m_hold;
                m_pend = 1'b0;
            end
            if (load) begin
                m_hold = value;
                m_pend = 1'b1;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
        check_eq("an", {12'd0, an}, {12'd0, e_an});
        check_eq("seg", {9'd0, seg}, {9'd0, e_seg});
        check_eq("dp", {15'd0, dp}, {15'd0, e_dp});
        check_eq("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
        check_eq("an_onehot", {15'd0, ($countones(~an) <= 1)}, 16'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (m_t % FRAME) != phase; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; value = 16'd0; load = 1'b0; dp_in = 4'd0; lz_en = 1'b0;
        m_t = 0; m_hold = 16'd0; m_disp = 16'd0; m_pend = 1'b0;
        run(3);
        rst = 1'b0;
        run(40);

        run_to(12);
        do_load(16'hA1F8);
        run(70);

        lz_en = 1'b1;
        do_load(16'h0030);
        run(70);
        lz_en = 1'b0;
        run(32);

        run_to(2);
        do_load(16'h1111);
        run(3);
        do_load(16'h2222);
        run_to(FRAME - 1);
        do_load(16'h4567);
        run(70);

        lz_en = 1'b1;
        dp_in = 4'b0101;
        do_load(16'h0005);
        run(70);
        do_load(16'h9306);
        run(70);

        run_to(2 * RD + 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(40);

        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom_range(0, 9) == 0);
            value = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 29) == 0) dp_in = 4'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
